// File: rtl/tile_renderer.sv
// Tile-map video renderer: raster timing, incremental block tracking, and a
// two-stage registered colour pipeline (objects > wall > grid > background).
module tile_renderer #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int MAP_COLS  = 40,
    parameter int MAP_ROWS  = 30,
    parameter int N_OBJ     = 2
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic                         i_PixEn,
    input  logic [1:0]                   i_Level,
    input  logic [MAP_COLS*MAP_ROWS-1:0] i_Map,
    input  logic [N_OBJ*6-1:0]           i_ObjPos_X,
    input  logic [N_OBJ*5-1:0]           i_ObjPos_Y,
    input  logic [N_OBJ*24-1:0]          i_ObjColor,
    input  logic                         i_GridEn,
    output logic [7:0]                   o_Red,
    output logic [7:0]                   o_Green,
    output logic [7:0]                   o_Blue,
    output logic                         o_hsync,
    output logic                         o_vsync,
    output logic                         o_blank,
    output logic                         o_fFrameStart,
    output logic                         o_fDrawDone
);

    localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int XW       = $clog2(H_TOTAL);
    localparam int YW       = $clog2(V_TOTAL);
    localparam int MAP_BITS = MAP_COLS * MAP_ROWS;
    localparam int MIW      = (MAP_BITS > 1) ? $clog2(MAP_BITS) : 1;

    logic [XW-1:0]  r_x;
    logic [XW-1:0]  r_col;
    logic [YW-1:0]  r_y;
    logic [YW-1:0]  r_row;
    logic [5:0]     r_xoff;
    logic [5:0]     r_yoff;
    logic [1:0]     r_level;

    logic           w_frame_start;
    logic           w_x_last;
    logic           w_y_last;
    logic [1:0]     w_level;
    logic [5:0]     w_bs_m1;

    assign w_frame_start = (r_x == '0) && (r_y == '0);
    assign w_x_last      = (int'(r_x) == H_TOTAL - 1);
    assign w_y_last      = (int'(r_y) == V_TOTAL - 1);
    // The level is captured on pixel (0,0), so that pixel already uses the new value.
    assign w_level       = w_frame_start ? i_Level : r_level;

    always_comb begin
        case (w_level)
            2'b10:   w_bs_m1 = 6'd19;
            2'b11:   w_bs_m1 = 6'd15;
            default: w_bs_m1 = 6'd39;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_xoff  <= '0;
            r_yoff  <= '0;
            r_level <= 2'b00;
        end else if (i_PixEn) begin
            if (w_frame_start) r_level <= i_Level;
            if (w_x_last) begin
                r_x    <= '0;
                r_col  <= '0;
                r_xoff <= '0;
                if (w_y_last) begin
                    r_y    <= '0;
                    r_row  <= '0;
                    r_yoff <= '0;
                end else begin
                    r_y <= r_y + 1'b1;
                    if (r_yoff == w_bs_m1) begin
                        r_yoff <= '0;
                        r_row  <= r_row + 1'b1;
                    end else begin
                        r_yoff <= r_yoff + 1'b1;
                    end
                end
            end else begin
                r_x <= r_x + 1'b1;
                if (r_xoff == w_bs_m1) begin
                    r_xoff <= '0;
                    r_col  <= r_col + 1'b1;
                end else begin
                    r_xoff <= r_xoff + 1'b1;
                end
            end
        end
    end

    logic           w_in_map;
    logic [MIW-1:0] w_map_idx;
    logic           w_wall;
    logic [N_OBJ-1:0] w_hit;

    assign w_in_map  = (int'(r_col) < MAP_COLS) && (int'(r_row) < MAP_ROWS);
    assign w_map_idx = MIW'(MAP_BITS - 1 - (int'(r_row) * MAP_COLS + int'(r_col)));

    always_comb begin
        w_wall = 1'b0;
        if (w_in_map) w_wall = i_Map[w_map_idx];
    end

    generate
        for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
            logic [5:0] w_ox;
            logic [4:0] w_oy;
            assign w_ox = i_ObjPos_X[gi*6 +: 6];
            assign w_oy = i_ObjPos_Y[gi*5 +: 5];
            // Channels parked outside the map never match, even if the raster overruns the map.
            assign w_hit[gi] = (int'(w_ox) < MAP_COLS) && (int'(w_oy) < MAP_ROWS)
                             && (int'(r_col) == int'(w_ox)) && (int'(r_row) == int'(w_oy));
        end
    endgenerate

    logic        w_active;
    logic        w_hsync;
    logic        w_vsync;
    logic [23:0] w_rgb;

    assign w_active = (int'(r_x) < H_DISPLAY) && (int'(r_y) < V_DISPLAY);
    assign w_hsync  = !((int'(r_x) >= H_DISPLAY + H_FP) && (int'(r_x) < H_DISPLAY + H_FP + H_SYNC));
    assign w_vsync  = !((int'(r_y) >= V_DISPLAY + V_FP) && (int'(r_y) < V_DISPLAY + V_FP + V_SYNC));

    // Lowest priority first; later assignments override earlier ones.
    always_comb begin
        w_rgb = 24'h000000;
        if (w_active && (w_level != 2'b00)) begin
            if (i_GridEn && ((r_xoff == '0) || (r_yoff == '0))) w_rgb = 24'h404040;
            if (w_wall) w_rgb = 24'hFFFFFF;
            for (int k = N_OBJ - 1; k >= 0; k--) begin
                if (w_hit[k]) w_rgb = i_ObjColor[k*24 +: 24];
            end
        end
    end

    logic [23:0] r_s1_rgb;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_blank;
    logic        r_s1_fs;
    logic        r_s1_fd;
    logic [23:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic        r_fs;
    logic        r_fd;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_s1_rgb   <= '0;
            r_s1_hsync <= 1'b1;
            r_s1_vsync <= 1'b1;
            r_s1_blank <= 1'b0;
            r_s1_fs    <= 1'b0;
            r_s1_fd    <= 1'b0;
            r_rgb      <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_blank    <= 1'b0;
            r_fs       <= 1'b0;
            r_fd       <= 1'b0;
        end else if (i_PixEn) begin
            r_s1_rgb   <= w_rgb;
            r_s1_hsync <= w_hsync;
            r_s1_vsync <= w_vsync;
            r_s1_blank <= w_active;
            r_s1_fs    <= w_frame_start;
            r_s1_fd    <= (int'(r_x) == H_DISPLAY - 1) && (int'(r_y) == V_DISPLAY - 1);
            r_rgb      <= r_s1_rgb;
            r_hsync    <= r_s1_hsync;
            r_vsync    <= r_s1_vsync;
            r_blank    <= r_s1_blank;
            r_fs       <= r_s1_fs;
            r_fd       <= r_s1_fd;
        end
    end

    assign o_Red         = r_rgb[23:16];
    assign o_Green       = r_rgb[15:8];
    assign o_Blue        = r_rgb[7:0];
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_blank       = r_blank;
    assign o_fFrameStart = r_fs;
    assign o_fDrawDone   = r_fd;

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer on a reduced raster: every output is compared each
// cycle against a division-based pixel model, plus directed scenario checks.
module tb_tile_renderer;

    localparam int HD = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VD = 84, VFP = 3, VSY = 2, VBP = 4;
    localparam int MC = 3, MR = 4, NO = 2;
    localparam int HT = HD + HFP + HSY + HBP;
    localparam int VT = VD + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int MB = MC * MR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, pixen, grid;
    logic [1:0]        level;
    logic [MB-1:0]     map;
    logic [NO*6-1:0]   ox;
    logic [NO*5-1:0]   oy;
    logic [NO*24-1:0]  ocol;
    logic [7:0]        red, green, blue;
    logic              hs, vs, blank, fs, fd;
    logic [28:0]       got;

    assign got = {red, green, blue, hs, vs, blank, fs, fd};

    tile_renderer #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .MAP_COLS(MC), .MAP_ROWS(MR), .N_OBJ(NO)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_PixEn(pixen), .i_Level(level),
        .i_Map(map), .i_ObjPos_X(ox), .i_ObjPos_Y(oy), .i_ObjColor(ocol),
        .i_GridEn(grid), .o_Red(red), .o_Green(green), .o_Blue(blue),
        .o_hsync(hs), .o_vsync(vs), .o_blank(blank),
        .o_fFrameStart(fs), .o_fDrawDone(fd)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          mx, my, p1x, p1y, poutx, pouty;
    logic [1:0]  mlevel;
    logic [28:0] p1, pout;
    logic [28:0] reset_vec;

    // Expected outputs for one pixel, straight from the colour/timing rules.
    function automatic logic [28:0] ref_pix(input int x, input int y, input logic [1:0] lvl);
        int bs, c, r, okx, oky;
        logic [23:0] rgb;
        logic [MB-1:0] mrow;
        logic hsn, vsn, act, hit;
        hsn = !(x >= HD + HFP && x < HD + HFP + HSY);
        vsn = !(y >= VD + VFP && y < VD + VFP + VSY);
        act = (x < HD) && (y < VD);
        rgb = 24'h0;
        hit = 1'b0;
        if (act && lvl != 2'd0) begin
            bs = (lvl == 2'd1) ? 40 : (lvl == 2'd2) ? 20 : 16;
            c = x / bs;
            r = y / bs;
            for (int k = 0; k < NO; k++) begin
                okx = int'(6'(ox >> (6 * k)));
                oky = int'(5'(oy >> (5 * k)));
                if (!hit && okx < MC && oky < MR && okx == c && oky == r) begin
                    rgb = 24'(ocol >> (24 * k));
                    hit = 1'b1;
                end
            end
            if (!hit && c < MC && r < MR) begin
                mrow = map >> (MB - 1 - (r * MC + c));
                if (mrow[0]) begin
                    rgb = 24'hFFFFFF;
                    hit = 1'b1;
                end
            end
            if (!hit && grid && ((x % bs) == 0 || (y % bs) == 0)) rgb = 24'h404040;
        end
        return {rgb, hsn, vsn, act, (x == 0 && y == 0), (x == HD - 1 && y == VD - 1)};
    endfunction

    task automatic tick(input logic en);
        pixen = en;
        @(posedge clk);
        if (en) begin
            if (mx == 0 && my == 0) mlevel = level;
            pout  = p1;
            poutx = p1x;
            pouty = p1y;
            p1    = ref_pix(mx, my, mlevel);
            p1x   = mx;
            p1y   = my;
            mx++;
            if (mx == HT) begin
                mx = 0;
                my++;
                if (my == VT) my = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        pixen = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst    = 1'b0;
        mx     = 0;
        my     = 0;
        mlevel = 2'b00;
        p1     = reset_vec;
        pout   = reset_vec;
        p1x    = -1;
        p1y    = -1;
        poutx  = -1;
        pouty  = -1;
    endtask

    function automatic int to_frame_end();
        return (FRAME - (my * HT + mx)) % FRAME;
    endfunction

    task automatic test_reset();
        do_reset(3);
        vectors++;
        if (got !== reset_vec) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", got, reset_vec);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            vectors++;
            if (got !== reset_vec) begin
                miscompares++;
                $display("FAIL reset_hold got=%h exp=%h", got, reset_vec);
            end
        end
        tick(1'b1);
        vectors++;
        if (got !== reset_vec) begin
            miscompares++;
            $display("FAIL first_enable got=%h exp=%h", got, reset_vec);
        end
        tick(1'b1);
        vectors++;
        if (fs !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_start_latency got=%b exp=1", fs);
        end
        $display("test_reset: done");
    endtask

    task automatic test_wall();
        for (int n = 0; n < FRAME && !(mx == 0 && my == 40); n++) begin
            tick(1'b1);
            vectors++;
            if (got !== pout) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL wall px(%0d,%0d) got=%h exp=%h", poutx, pouty, got, pout);
            end
            if (pouty >= 0 && pouty < 40 && poutx >= 0 && poutx < HD) begin
                vectors++;
                if (got[28:5] !== ((poutx >= 40) ? 24'hFFFFFF : 24'h000000)) begin
                    miscompares++;
                    if (miscompares <= 20) $display("FAIL wall_block px(%0d,%0d) got=%h", poutx, pouty, got[28:5]);
                end
            end
        end
        $display("test_wall: done at line %0d", my);
    endtask

    task automatic test_level_switch();
        int n_cyc;
        level = 2'b11;
        n_cyc = to_frame_end() + 50 * HT;
        for (int n = 0; n < n_cyc; n++) begin
            tick(1'b1);
            vectors++;
            if (got !== pout) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL level_switch px(%0d,%0d) got=%h exp=%h", poutx, pouty, got, pout);
            end
        end
        $display("test_level_switch: done, latched level %0d", mlevel);
    endtask

    task automatic test_objects();
        int n_cyc;
        level = 2'b10;
        ox    = {6'd2, 6'd2};
        oy    = {5'd3, 5'd3};
        ocol  = {24'h00FF00, 24'hFF0000};
        map   = MB'($urandom);
        grid  = 1'b1;
        n_cyc = to_frame_end() + FRAME;
        for (int n = 0; n < n_cyc; n++) begin
            tick(1'b1);
            vectors++;
            if (got !== pout) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL objects px(%0d,%0d) got=%h exp=%h", poutx, pouty, got, pout);
            end
            if (mlevel == 2'b10 && poutx >= 40 && poutx < 60 && pouty >= 60 && pouty < 80) begin
                vectors++;
                if (got[28:5] !== 24'hFF0000) begin
                    miscompares++;
                    if (miscompares <= 20) $display("FAIL obj_priority px(%0d,%0d) got=%h exp=ff0000", poutx, pouty, got[28:5]);
                end
            end
        end
        $display("test_objects: done");
    endtask

    task automatic test_grid();
        int n_cyc;
        logic [23:0] exp_rgb;
        level = 2'b11;
        map   = '0;
        grid  = 1'b1;
        ox    = {6'd1, 6'd3};
        oy    = {5'd4, 5'd0};
        n_cyc = to_frame_end() + FRAME;
        for (int n = 0; n < n_cyc; n++) begin
            tick(1'b1);
            vectors++;
            if (got !== pout) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL grid px(%0d,%0d) got=%h exp=%h", poutx, pouty, got, pout);
            end
            if (mlevel == 2'b11 && poutx >= 0) begin
                if (poutx < HD && pouty < VD && ((poutx % 16) == 0 || (pouty % 16) == 0)) exp_rgb = 24'h404040;
                else exp_rgb = 24'h000000;
                vectors++;
                if (got[28:5] !== exp_rgb) begin
                    miscompares++;
                    if (miscompares <= 20) $display("FAIL grid_line px(%0d,%0d) got=%h exp=%h", poutx, pouty, got[28:5], exp_rgb);
                end
            end
        end
        $display("test_grid: done");
    endtask

    task automatic test_pixen_toggle();
        logic        en, started, done;
        logic [28:0] prev;
        int          ecount, vlow, hlow, fdcount;
        level   = 2'($urandom_range(1, 3));
        map     = MB'($urandom);
        grid    = 1'($urandom);
        ox      = {6'($urandom_range(0, 4)), 6'($urandom_range(0, 4))};
        oy      = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
        ocol    = {24'($urandom), 24'($urandom)};
        started = 1'b0;
        done    = 1'b0;
        ecount  = 0;
        vlow    = 0;
        hlow    = 0;
        fdcount = 0;
        for (int n = 0; n < 4 * FRAME && !done; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            prev = got;
            tick(en);
            vectors++;
            if (got !== pout) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL toggle px(%0d,%0d) got=%h exp=%h", poutx, pouty, got, pout);
            end
            if (!en) begin
                vectors++;
                if (got !== prev) begin
                    miscompares++;
                    if (miscompares <= 20) $display("FAIL hold got=%h exp=%h", got, prev);
                end
            end else begin
                if (fs && started) done = 1'b1;
                else if (fs) started = 1'b1;
                if (started && !done) begin
                    ecount++;
                    if (!vs) vlow++;
                    if (!hs) hlow++;
                    if (fd) fdcount++;
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL frame_timeout got=no second frame start exp=within %0d cycles", 4 * FRAME);
        end
        vectors++;
        if (ecount != FRAME) begin
            miscompares++;
            $display("FAIL frame_length got=%0d exp=%0d", ecount, FRAME);
        end
        vectors++;
        if (vlow != VSY * HT) begin
            miscompares++;
            $display("FAIL vsync_low got=%0d exp=%0d", vlow, VSY * HT);
        end
        vectors++;
        if (hlow != HSY * VT) begin
            miscompares++;
            $display("FAIL hsync_low got=%0d exp=%0d", hlow, HSY * VT);
        end
        vectors++;
        if (fdcount != 1) begin
            miscompares++;
            $display("FAIL draw_done_count got=%0d exp=1", fdcount);
        end
        $display("test_pixen_toggle: frame of %0d enabled cycles", ecount);
    endtask

    task automatic test_mid_reset();
        level = 2'b01;
        map   = MB'($urandom);
        for (int n = 0; n < 3 * HT + 17; n++) begin
            tick(1'b1);
            vectors++;
            if (got !== pout) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL pre_reset px(%0d,%0d) got=%h exp=%h", poutx, pouty, got, pout);
            end
        end
        level = 2'b00;
        grid  = 1'b1;
        map   = '1;
        ox    = {6'd0, 6'd0};
        oy    = {5'd0, 5'd0};
        do_reset(2);
        vectors++;
        if (got !== reset_vec) begin
            miscompares++;
            $display("FAIL midreset_state got=%h exp=%h", got, reset_vec);
        end
        for (int n = 0; n < FRAME + 2; n++) begin
            tick(1'b1);
            vectors++;
            if (got !== pout) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL level_off px(%0d,%0d) got=%h exp=%h", poutx, pouty, got, pout);
            end
            vectors++;
            if (got[28:5] !== 24'h000000) begin
                miscompares++;
                if (miscompares <= 20) $display("FAIL level_off_black px(%0d,%0d) got=%h exp=000000", poutx, pouty, got[28:5]);
            end
        end
        $display("test_mid_reset: done");
    endtask

    initial begin
        reset_vec = {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst   = 1'b1;
        pixen = 1'b0;
        level = 2'b01;
        map   = '0;
        map[MB - 1 - 1] = 1'b1;
        ox    = {6'd63, 6'd63};
        oy    = {5'd31, 5'd31};
        ocol  = {24'($urandom), 24'($urandom)};
        grid  = 1'b0;
        test_reset();
        test_wall();
        test_level_switch();
        test_objects();
        test_grid();
        test_pixen_toggle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
